// File: rtl/cpu_bus_serializer_if.sv
// Parallel CPU request/response signals plus the narrow framed pin bus.
// master: CPU and external device side; slave: the serializer.
interface cpu_bus_serializer_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PIN_W  = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [PIN_W-1:0]  pin_out;
    logic              pin_oe;
    logic [PIN_W-1:0]  pin_in;
    logic              pin_frame;
    logic              pin_cmd;
    logic              ext_wait;

    modport master (
        output req, we, addr, wdata, pin_in, ext_wait,
        input  rdata, busy, done, err, pin_out, pin_oe, pin_frame, pin_cmd
    );

    modport slave (
        input  req, we, addr, wdata, pin_in, ext_wait,
        output rdata, busy, done, err, pin_out, pin_oe, pin_frame, pin_cmd
    );
endinterface

// File: rtl/cpu_bus_serializer.sv
// Serializes one CPU transfer into framed address/command/data beats on a narrow pin bus,
// with per-beat external stall and an optional stall timeout.
module cpu_bus_serializer #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned PIN_W    = 8,
    parameter int unsigned WAIT_MAX = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    cpu_bus_serializer_if.slave   bus
);

    localparam int unsigned A      = ADDR_W / PIN_W;
    localparam int unsigned D      = DATA_W / PIN_W;
    localparam int unsigned MAXB   = (A > D) ? A : D;
    localparam int unsigned BEAT_W = (MAXB > 1) ? $clog2(MAXB) : 1;
    localparam int unsigned WAIT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CMD,
        S_WDATA,
        S_TURN,
        S_RDATA,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [WAIT_W-1:0]   wait_q, wait_d, wait_inc;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   shadow_q, shadow_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [PIN_W-1:0]    pin_out_q, pin_out_d;
    logic                pin_oe_q, pin_oe_d;
    logic                pin_frame_q, pin_frame_d;
    logic                pin_cmd_q, pin_cmd_d;
    logic                timeout;
    logic                last_a;
    logic                last_d;

    // State, operand and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            wait_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            shadow_q    <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            pin_out_q   <= '0;
            pin_oe_q    <= 1'b0;
            pin_frame_q <= 1'b0;
            pin_cmd_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            wait_q      <= wait_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            shadow_q    <= shadow_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            pin_out_q   <= pin_out_d;
            pin_oe_q    <= pin_oe_d;
            pin_frame_q <= pin_frame_d;
            pin_cmd_q   <= pin_cmd_d;
        end
    end

    // Next state, then outputs decoded from the next registered values
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        wait_d      = wait_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        shadow_d    = shadow_q;
        rdata_d     = rdata_q;
        err_d       = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        pin_out_d   = '0;
        pin_oe_d    = 1'b0;
        pin_frame_d = 1'b0;
        pin_cmd_d   = 1'b0;

        wait_inc = (wait_q == '1) ? wait_q : wait_q + WAIT_W'(1);
        timeout  = (WAIT_MAX != 0) && (wait_inc == WAIT_W'(WAIT_MAX));
        last_a   = (beat_q == BEAT_W'(A - 1));
        last_d   = (beat_q == BEAT_W'(D - 1));

        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    we_d    = bus.we;
                    beat_d  = '0;
                    wait_d  = '0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR, S_CMD, S_WDATA, S_RDATA: begin
                if (bus.ext_wait) begin
                    wait_d = wait_inc;
                    if (timeout) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                        beat_d  = '0;
                        wait_d  = '0;
                    end
                end else begin
                    wait_d = '0;
                    beat_d = beat_q + BEAT_W'(1);
                    case (state_q)
                        S_ADDR: begin
                            if (last_a) begin
                                beat_d  = '0;
                                state_d = S_CMD;
                            end
                        end
                        S_CMD: begin
                            beat_d  = '0;
                            state_d = we_q ? S_WDATA : S_TURN;
                        end
                        S_WDATA: begin
                            if (last_d) begin
                                beat_d  = '0;
                                state_d = S_DONE;
                            end
                        end
                        default: begin
                            for (int unsigned k = 0; k < D; k++) begin
                                if (beat_q == BEAT_W'(k)) begin
                                    shadow_d[k*PIN_W +: PIN_W] = bus.pin_in;
                                end
                            end
                            if (last_d) begin
                                beat_d  = '0;
                                state_d = S_DONE;
                                rdata_d = shadow_d;
                            end
                        end
                    endcase
                end
            end
            S_TURN: begin
                beat_d  = '0;
                wait_d  = '0;
                state_d = S_RDATA;
            end
            S_DONE: begin
                beat_d  = '0;
                wait_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        pin_cmd_d   = (state_d == S_CMD);
        pin_oe_d    = state_d inside {S_ADDR, S_CMD, S_WDATA};
        pin_frame_d = state_d inside {S_ADDR, S_CMD, S_WDATA, S_TURN, S_RDATA};

        case (state_d)
            S_ADDR: begin
                for (int unsigned k = 0; k < A; k++) begin
                    if (beat_d == BEAT_W'(k)) begin
                        pin_out_d = addr_d[k*PIN_W +: PIN_W];
                    end
                end
            end
            S_CMD: begin
                pin_out_d = {{(PIN_W - 1){1'b0}}, we_d};
            end
            S_WDATA: begin
                for (int unsigned k = 0; k < D; k++) begin
                    if (beat_d == BEAT_W'(k)) begin
                        pin_out_d = wdata_d[k*PIN_W +: PIN_W];
                    end
                end
            end
            default: begin
                pin_out_d = '0;
            end
        endcase
    end

    assign bus.rdata     = rdata_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.pin_out   = pin_out_q;
    assign bus.pin_oe    = pin_oe_q;
    assign bus.pin_frame = pin_frame_q;
    assign bus.pin_cmd   = pin_cmd_q;

endmodule
